// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: predictor counter encodings and default PC step.
package cpu_pkg;

  // 2-bit branch direction counter states
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam int unsigned DEF_PC_INCR = 4;
  localparam int unsigned STAT_W      = 16;

endpackage : cpu_pkg

// File: rtl/sat_ctr.sv
// 2-bit saturating counter next-state function.
module sat_ctr
  import cpu_pkg::*;
(
  input  ctr_e cnt,
  input  logic inc,
  output ctr_e cnt_nxt
);

  // Step up on inc, down otherwise; hold at the ends
  always_comb begin
    cnt_nxt = cnt;
    unique case (cnt)
      CTR_SNT: cnt_nxt = inc ? CTR_WNT : CTR_SNT;
      CTR_WNT: cnt_nxt = inc ? CTR_WT  : CTR_SNT;
      CTR_WT:  cnt_nxt = inc ? CTR_ST  : CTR_WNT;
      CTR_ST:  cnt_nxt = inc ? CTR_ST  : CTR_WT;
      default: cnt_nxt = cnt;
    endcase
  end

endmodule : sat_ctr

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PC_INCR = DEF_PC_INCR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  output logic [PC_W-1:0]   next_pc,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [PC_W-1:0]   upd_target,
  input  logic [PC_W-1:0]   upd_fallthru,
  input  logic              upd_taken,
  input  logic              upd_pred_taken,
  input  logic [PC_W-1:0]   upd_pred_target,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  input  logic              clear,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int unsigned OFF_W = $clog2(PC_INCR);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - OFF_W - IDX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [PC_W-1:0]    tgt_d [ENTRIES];
  ctr_e               ctr_q [ENTRIES];
  ctr_e               ctr_d [ENTRIES];
  logic [STAT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [STAT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]   f_idx, u_idx;
  logic [TAG_W-1:0]   f_tag, u_tag;
  logic               f_hit, u_hit;
  logic [PC_W-1:0]    fetch_seq;
  ctr_e               u_ctr_cur, u_ctr_nxt;

  // Offset bits of the update PC carry no information for the table
  logic unused_upd_off;
  assign unused_upd_off = ^(upd_pc & PC_W'(PC_INCR - 1));

  // Fetch-side lookup; pre-update contents, forced to miss while in reset
  always_comb begin
    f_idx       = fetch_pc[OFF_W +: IDX_W];
    f_tag       = fetch_pc[OFF_W + IDX_W +: TAG_W];
    fetch_seq   = fetch_pc + PC_W'(PC_INCR);
    f_hit       = rst_n && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = f_hit && (ctr_q[f_idx] inside {CTR_WT, CTR_ST});
    pred_target = f_hit ? tgt_q[f_idx] : fetch_seq;
    next_pc     = pred_taken ? pred_target : fetch_seq;
  end

  // Resolution-side compare against the prediction carried down the pipe
  always_comb begin
    mispredict  = upd_valid &&
                  ((upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_fallthru;
  end

  // Update-side lookup
  always_comb begin
    u_idx     = upd_pc[OFF_W +: IDX_W];
    u_tag     = upd_pc[OFF_W + IDX_W +: TAG_W];
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_ctr_cur = ctr_q[u_idx];
  end

  sat_ctr u_sat_ctr (
    .cnt     (u_ctr_cur),
    .inc     (upd_taken),
    .cnt_nxt (u_ctr_nxt)
  );

  // Table next state: clear wins over training; only taken misses allocate
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (clear) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (u_hit) begin
        ctr_d[u_idx] = u_ctr_nxt;
        if (upd_taken) tgt_d[u_idx] = upd_target;
      end else if (upd_taken) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = upd_target;
        ctr_d[u_idx]   = CTR_WT;
      end
    end
  end

  // Saturating statistics
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (upd_valid && (br_cnt_q != '1))   br_cnt_d   = br_cnt_q + STAT_W'(1);
    if (mispredict && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + STAT_W'(1);
  end

  // Control state: valid bits, counters and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= CTR_WNT;
    end else begin
      valid_q    <= valid_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      ctr_q      <= ctr_d;
    end
  end

  // Payload state: tags and targets are qualified by valid, so no reset
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor with a reference table model and scoreboard.
module tb_branch_predictor;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned PC_INCR = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [PC_W-1:0] fetch_pc = '0;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic [PC_W-1:0] next_pc;
  logic            upd_valid = 1'b0;
  logic [PC_W-1:0] upd_pc = '0;
  logic [PC_W-1:0] upd_target = '0;
  logic [PC_W-1:0] upd_fallthru = '0;
  logic            upd_taken = 1'b0;
  logic            upd_pred_taken = 1'b0;
  logic [PC_W-1:0] upd_pred_target = '0;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic            clear = 1'b0;
  logic [15:0]     br_cnt;
  logic [15:0]     miss_cnt;

  always #5 clk = ~clk;

  branch_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .PC_INCR(PC_INCR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .next_pc         (next_pc),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_target      (upd_target),
    .upd_fallthru    (upd_fallthru),
    .upd_taken       (upd_taken),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .clear           (clear),
    .br_cnt          (br_cnt),
    .miss_cnt        (miss_cnt)
  );

  typedef struct {
    bit          pt;
    logic [15:0] ptgt;
    logic [15:0] npc;
    bit          mp;
    logic [15:0] rpc;
    logic [15:0] br;
    logic [15:0] miss;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b1;

  // Reference model state
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [15:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_br;
  int unsigned m_miss;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int unsigned midx(input logic [15:0] pc);
    int unsigned p = 32'(pc);
    return (p / PC_INCR) % ENTRIES;
  endfunction

  function automatic int unsigned mtag(input logic [15:0] pc);
    int unsigned p = 32'(pc);
    return p / (PC_INCR * ENTRIES);
  endfunction

  function automatic bit mhit(input logic [15:0] pc);
    return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction

  function automatic bit mpt(input logic [15:0] pc);
    return mhit(pc) && (m_ctr[midx(pc)] >= 2);
  endfunction

  function automatic logic [15:0] mptgt(input logic [15:0] pc);
    return mhit(pc) ? m_tgt[midx(pc)] : pc + 16'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
    end
    m_br   = 0;
    m_miss = 0;
  endtask

  // Drive one cycle of inputs, push the expectation, then compare the DUT outputs
  task automatic drive(input logic [15:0] fpc, input bit uv, input logic [15:0] upc,
                       input logic [15:0] utgt, input bit ut, input bit upt,
                       input logic [15:0] uptgt, input bit clr);
    exp_t e;
    exp_t got;
    fetch_pc        = fpc;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_target      = utgt;
    upd_fallthru    = upc + 16'd4;
    upd_taken       = ut;
    upd_pred_taken  = upt;
    upd_pred_target = uptgt;
    clear           = clr;
    e.pt   = mpt(fpc);
    e.ptgt = mptgt(fpc);
    e.npc  = e.pt ? e.ptgt : fpc + 16'd4;
    e.mp   = uv && ((ut != upt) || (ut && (utgt != uptgt)));
    e.rpc  = ut ? utgt : upc + 16'd4;
    e.br   = 16'(m_br);
    e.miss = 16'(m_miss);
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    if (chk_en) begin
      check_val("pred_taken",  32'(pred_taken),  32'(got.pt));
      check_val("pred_target", 32'(pred_target), 32'(got.ptgt));
      check_val("next_pc",     32'(next_pc),     32'(got.npc));
      check_val("mispredict",  32'(mispredict),  32'(got.mp));
      if (got.mp) check_val("redirect_pc", 32'(redirect_pc), 32'(got.rpc));
      check_val("br_cnt",      32'(br_cnt),      32'(got.br));
      check_val("miss_cnt",    32'(miss_cnt),    32'(got.miss));
    end
  endtask

  // Cross the rising edge and move the model forward with the same inputs
  task automatic adv();
    bit mp;
    int unsigned i;
    mp = upd_valid && ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (upd_valid && (m_br < 32'hFFFF)) m_br++;
      if (mp && (m_miss < 32'hFFFF)) m_miss++;
      if (clear) begin
        for (int k = 0; k < int'(ENTRIES); k++) m_valid[k] = 1'b0;
      end else if (upd_valid) begin
        i = midx(upd_pc);
        if (mhit(upd_pc)) begin
          if (upd_taken) begin
            if (m_ctr[i] < 3) m_ctr[i]++;
            m_tgt[i] = upd_target;
          end else if (m_ctr[i] > 0) begin
            m_ctr[i]--;
          end
        end else if (upd_taken) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = mtag(upd_pc);
          m_tgt[i]   = upd_target;
          m_ctr[i]   = 2;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic [15:0] fpc, input bit uv, input logic [15:0] upc,
                     input logic [15:0] utgt, input bit ut, input bit upt,
                     input logic [15:0] uptgt, input bit clr);
    drive(fpc, uv, upc, utgt, ut, upt, uptgt, clr);
    adv();
  endtask

  // Lookup only, no edge crossed
  task automatic look(input logic [15:0] fpc);
    drive(fpc, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  // Update using the model's current prediction for that PC
  task automatic train(input logic [15:0] fpc, input logic [15:0] upc,
                       input logic [15:0] utgt, input bit ut);
    cyc(fpc, 1'b1, upc, utgt, ut, mpt(upc), mptgt(upc), 1'b0);
  endtask

  initial begin
    logic [15:0] pool [8];
    logic [15:0] tgts [4];
    logic [15:0] upc;
    bit          upt;
    pool = '{16'h0000, 16'h0040, 16'h0440, 16'h0080, 16'h003C, 16'h07C0, 16'h1040, 16'h0004};
    tgts = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    model_reset();

    // Reset held across edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    look(16'h0040);
    check_val("rst_pred_taken", 32'(pred_taken), 32'h0);
    check_val("rst_next_pc", 32'(next_pc), 32'h0044);
    check_val("rst_br_cnt", 32'(br_cnt), 32'h0);
    adv();
    rst_n = 1'b1;

    // Cold miss
    look(16'h0040);
    check_val("cold_pred_taken", 32'(pred_taken), 32'h0);
    check_val("cold_next_pc", 32'(next_pc), 32'h0044);

    // Allocation on taken miss
    drive(16'h0040, 1'b1, 16'h0040, 16'h0100, 1'b1, 1'b0, 16'h0044, 1'b0);
    check_val("alloc_mispredict", 32'(mispredict), 32'h1);
    check_val("alloc_redirect", 32'(redirect_pc), 32'h0100);
    adv();
    look(16'h0040);
    check_val("alloc_pred_taken", 32'(pred_taken), 32'h1);
    check_val("alloc_pred_target", 32'(pred_target), 32'h0100);
    check_val("alloc_br_cnt", 32'(br_cnt), 32'h1);
    check_val("alloc_miss_cnt", 32'(miss_cnt), 32'h1);

    // Hysteresis
    train(16'h0040, 16'h0040, 16'h0100, 1'b0);
    look(16'h0040);
    check_val("hyst_wnt", 32'(pred_taken), 32'h0);
    train(16'h0040, 16'h0040, 16'h0100, 1'b1);
    train(16'h0040, 16'h0040, 16'h0100, 1'b1);
    train(16'h0040, 16'h0040, 16'h0100, 1'b0);
    look(16'h0040);
    check_val("hyst_wt", 32'(pred_taken), 32'h1);

    // Tag alias replaces the entry
    look(16'h0440);
    check_val("alias_miss", 32'(pred_taken), 32'h0);
    train(16'h0440, 16'h0440, 16'h0200, 1'b1);
    look(16'h0440);
    check_val("alias_hit_target", 32'(pred_target), 32'h0200);
    look(16'h0040);
    check_val("alias_old_miss", 32'(pred_taken), 32'h0);

    // Same-cycle lookup and update at index 0
    drive(16'h0000, 1'b1, 16'h0000, 16'h0300, 1'b1, 1'b0, 16'h0004, 1'b0);
    check_val("same_cyc_old", 32'(pred_taken), 32'h0);
    adv();
    look(16'h0000);
    check_val("same_cyc_new", 32'(pred_taken), 32'h1);
    check_val("same_cyc_tgt", 32'(pred_target), 32'h0300);

    // Taken hit with a new target
    train(16'h0000, 16'h0000, 16'h0380, 1'b1);
    look(16'h0000);
    check_val("retarget", 32'(pred_target), 32'h0380);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      upc = pool[$urandom_range(0, 7)];
      upt = mpt(upc);
      if ($urandom_range(0, 3) == 0) upt = ~upt;
      cyc(pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), upc,
          tgts[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), upt,
          ($urandom_range(0, 3) == 0) ? tgts[$urandom_range(0, 3)] : mptgt(upc),
          ($urandom_range(0, 49) == 0));
    end

    // Clear with a simultaneous taken update
    train(16'h0000, 16'h0000, 16'h0380, 1'b1);
    cyc(16'h0000, 1'b1, 16'h0080, 16'h0500, 1'b1, 1'b0, 16'h0084, 1'b1);
    look(16'h0000);
    check_val("clear_idx0", 32'(pred_taken), 32'h0);
    look(16'h0080);
    check_val("clear_no_alloc", 32'(pred_taken), 32'h0);

    // Statistics saturation
    chk_en = 1'b0;
    for (int n = 0; n < 65540; n++)
      cyc(16'h1000, 1'b1, 16'h1000, 16'h0000, 1'b0, 1'b0, 16'h1004, 1'b0);
    chk_en = 1'b1;
    look(16'h1000);
    check_val("br_cnt_sat", 32'(br_cnt), 32'hFFFF);
    cyc(16'h1000, 1'b1, 16'h1000, 16'h0000, 1'b0, 1'b0, 16'h1004, 1'b0);
    look(16'h1000);
    check_val("br_cnt_hold", 32'(br_cnt), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_branch_predictor
